// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   mdu_op_e        - operation codes presented on op by the EX stage
//   mdu_state_e     - controller state (IDLE: no operation in flight)
//   *_CYCLES_DEF    - default busy lengths for multiply and divide
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage <-> multiply/divide unit bus.
//   start   EX instruction is an MDU operation this cycle
//   op      operation code (mdu_pkg::mdu_op_e encoding)
//   a, b    forwarded rs / rt values
//   busy    multi-cycle operation in flight
//   hi, lo  HI / LO register contents
// master = EX stage / hazard side, slave = mdu.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_calc.sv
// mdu_calc: combinational arithmetic for the MDU.
//   op              operation code
//   a, b            operands (rs, rt)
//   hi_cur, lo_cur  current HI/LO, returned unchanged on divide by zero
//   result          {hi, lo} the operation will produce
// Multiply: 64-bit product, signed or unsigned.
// Divide: {remainder, quotient}; signed quotient truncates toward zero and
// the remainder follows the dividend's sign.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_cur,
  input  logic [31:0] lo_cur,
  output logic [63:0] result
);

  logic        sgn_div;
  logic [31:0] a_mag, b_mag;
  logic [31:0] dvd, dvs;
  logic [31:0] q_mag, r_mag;
  logic [31:0] q, r;
  logic [63:0] mul_a, mul_b;

  always_comb begin
    sgn_div = (op == MDU_DIV);
    a_mag   = a[31] ? (~a + 32'd1) : a;
    b_mag   = b[31] ? (~b + 32'd1) : b;

    // One unsigned divider serves both flavours; signed divide works on
    // magnitudes and fixes signs afterwards, which also makes
    // 0x80000000 / -1 fall out as 0x80000000 rem 0 without overflow.
    dvd = sgn_div ? a_mag : a;
    dvs = sgn_div ? b_mag : b;

    q_mag = '0;
    r_mag = '0;
    if (dvs != '0) begin
      q_mag = dvd / dvs;
      r_mag = dvd % dvs;
    end
    q = (sgn_div && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    r = (sgn_div && a[31])           ? (~r_mag + 32'd1) : r_mag;

    // Low 64 bits of a 64x64 product of sign/zero-extended operands equal
    // the full 32x32 signed/unsigned product.
    mul_a = (op == MDU_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
    mul_b = (op == MDU_MULT) ? {{32{b[31]}}, b} : {32'd0, b};

    result = {hi_cur, lo_cur};
    case (op)
      MDU_MULT, MDU_MULTU: result = mul_a * mul_b;
      MDU_DIV, MDU_DIVU: begin
        if (b != '0) result = {r, q};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit owning HI/LO, EX stage.
//   clk    pipeline clock
//   reset  asynchronous, active-high; clears all state
//   bus    mdu_if.slave: start/op/a/b in, busy/hi/lo out
// mult/multu/div/divu compute their result at the accepting edge into a
// pending register, hold busy for MULT_CYCLES / DIV_CYCLES, and commit to
// HI/LO on the edge busy falls. mthi/mtlo write immediately. A start seen
// while busy, or with an unknown op, is ignored.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int unsigned CYC_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CYC_MAX + 1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      pend_q;
  logic [31:0]      hi_q, lo_q;
  logic [63:0]      calc_res;

  mdu_calc u_calc (
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .hi_cur (hi_q),
    .lo_cur (lo_q),
    .result (calc_res)
  );

  // state_q is ST_RUN exactly while cnt_q != 0, so busy comes straight
  // from a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MDU_MULT, MDU_MULTU: begin
                pend_q  <= calc_res;
                cnt_q   <= CNT_W'(MULT_CYCLES);
                state_q <= ST_RUN;
              end
              MDU_DIV, MDU_DIVU: begin
                pend_q  <= calc_res;
                cnt_q   <= CNT_W'(DIV_CYCLES);
                state_q <= ST_RUN;
              end
              MDU_MTHI: hi_q <= bus.a;
              MDU_MTLO: lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= pend_q[63:32];
            lo_q    <= pend_q[31:0];
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu. The driver issues operations, computes
// the expected HI/LO and busy length with plain integer arithmetic, and
// queues them; the monitor pops an entry when busy falls (or, for
// zero-cycle entries, on the next sample with busy low) and compares.
module tb_mdu;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if bus ();

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: architectural effect of one accepted operation.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int unsigned cycles);
    longint          ps;
    longint unsigned pu;
    int              sa, sb_v, qs, rs;
    sa = int'(a);
    sb_v = int'(b);
    cycles = 0;
    case (op)
      3'd0: begin
        ps = longint'(sa) * longint'(sb_v);
        m_hi = ps[63:32]; m_lo = ps[31:0]; cycles = MC;
      end
      3'd1: begin
        pu = 64'(a) * 64'(b);
        m_hi = pu[63:32]; m_lo = pu[31:0]; cycles = MC;
      end
      3'd2: begin
        cycles = DC;
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000; m_hi = 32'h0;
          end else begin
            qs = sa / sb_v; rs = sa % sb_v;
            m_lo = qs; m_hi = rs;
          end
        end
      end
      3'd3: begin
        cycles = DC;
        if (b != 0) begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic push_chk(input string name);
    sb.push_back('{name, m_hi, m_lo, 0});
  endtask

  // Waits for idle (bounded), drives one start cycle, queues the expectation.
  // Called at a negedge; returns at the next negedge with start dropped.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int          guard;
    int unsigned cyc;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL %s: busy stuck high, got 1, want 0 within 200 cycles", name);
    end
    #1;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    model_op(op, a, b, cyc);
    sb.push_back('{name, m_hi, m_lo, cyc});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Start pulse while busy: must be ignored, so nothing is queued.
  task automatic poke(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    #1;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Monitor
  initial begin
    logic        prev;
    int unsigned cnt;
    int          age;
    exp_t        e;
    prev = 1'b0; cnt = 0; age = 0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) cnt++;
      if (sb.size() > 0) begin
        age++;
        if (bus.busy === 1'b0 && (prev || sb[0].cycles == 0)) begin
          e = sb.pop_front();
          check32({e.name, ".hi"}, bus.hi, e.hi);
          check32({e.name, ".lo"}, bus.lo, e.lo);
          check32({e.name, ".busy_cycles"}, cnt, e.cycles);
          cnt = 0; age = 0;
        end else if (age > int'(DC) + 20) begin
          e = sb.pop_front();
          n_cmp++; n_err++;
          $display("FAIL %s.timeout: got no busy fall, want one within %0d cycles", e.name, DC + 20);
          cnt = 0; age = 0;
        end
      end else if (bus.busy === 1'b1 && !prev) begin
        check32("spurious_busy", 32'(bus.busy), 32'd0);
      end
      prev = (bus.busy === 1'b1);
    end
  end

  // Driver
  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          guard;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    #2;
    check32("reset.busy", 32'(bus.busy), 32'd0);
    check32("reset.hi", bus.hi, 32'd0);
    check32("reset.lo", bus.lo, 32'd0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    issue("mult_m2x3",  3'd0, 32'hFFFF_FFFE, 32'd3);
    issue("multu_m2x3", 3'd1, 32'hFFFF_FFFE, 32'd3);
    issue("div_m7d2",   3'd2, 32'hFFFF_FFF9, 32'd2);
    issue("divu_7d2",   3'd3, 32'd7, 32'd2);
    issue("mthi_1234",  3'd4, 32'h1234, 32'd0);
    issue("mtlo_5678",  3'd5, 32'h5678, 32'd0);
    issue("div_by0",    3'd2, 32'd99, 32'd0);
    issue("divu_by0",   3'd3, 32'd99, 32'd0);
    issue("div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue("mthi_dead",  3'd4, 32'hDEAD_BEEF, 32'd0);
    issue("bad_op6",    3'd6, 32'h1111_1111, 32'h2222_2222);
    issue("bad_op7",    3'd7, 32'h3333_3333, 32'h4444_4444);

    // Ignored start in a multu busy window, then a div at the first idle cycle.
    issue("multu_ign", 3'd1, 32'h89AB_CDEF, 32'h1234_5678);
    @(negedge clk);
    poke(3'd2, 32'd100, 32'd7);
    poke(3'd4, 32'hFFFF_FFFF, 32'd0);
    issue("div_b2b", 3'd2, 32'd100, 32'd7);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
    end

    // Reset during the third busy cycle of a div.
    issue("mthi_pre", 3'd4, 32'hCAFE_0001, 32'd0);
    issue("mtlo_pre", 3'd5, 32'hCAFE_0002, 32'd0);
    guard = 0;
    while (bus.busy === 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    #1;
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd1000; bus.b = 32'd3;
    sb.push_back('{"div_reset", 32'd0, 32'd0, 3});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check32("midrun_reset.busy", 32'(bus.busy), 32'd0);
    check32("midrun_reset.hi", bus.hi, 32'd0);
    check32("midrun_reset.lo", bus.lo, 32'd0);
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (15) @(negedge clk);
    #1 push_chk("post_reset_quiet");
    @(negedge clk);
    issue("mult_after_reset", 3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
